// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the 6502 core slice.
// Provides the instruction-source encodings reported on int_src and the
// default widths and break opcode used by the sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    INT_NONE = 2'b00,
    INT_IRQ  = 2'b01,
    INT_NMI  = 2'b10,
    INT_RST  = 2'b11
  } int_src_t;

  localparam int unsigned DEF_IR_W   = 8;
  localparam int unsigned DEF_CYC_W  = 3;
  localparam logic [7:0]  DEF_BRK_OP = 8'h00;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector with a configurable reset value for the delayed copy.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, loads q with RST_VAL
//   d    - input level
//   rise - high for the clock in which d is high and was low last clock
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

  assign rise = d && !q;

endmodule

// File: rtl/instr_seq.sv
// Instruction register and timing-cycle sequencer for the 6502 core.
// Tracks the timing cycle, latches the opcode on entry to the fetch cycle,
// and substitutes the break opcode for reset, NMI and IRQ.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   data_in            - opcode from the data bus
//   irq, nmi, i_flag   - interrupt inputs (irq level, nmi rising edge)
//   cyc_rst/inc/skip   - cycle control strobes (priority in that order)
//   ir                 - current instruction
//   cycle              - current timing cycle
//   int_src            - source of current instruction (cpu_pkg::int_src_t)
//   sync               - high while cycle equals FETCH_CYC
//   nmi_pend           - NMI edge captured, not yet serviced
module instr_seq
  import cpu_pkg::*;
#(
  parameter int unsigned      IR_W      = DEF_IR_W,
  parameter int unsigned      CYC_W     = DEF_CYC_W,
  parameter int unsigned      FETCH_CYC = 1,
  parameter logic [IR_W-1:0]  BRK_OP    = IR_W'(DEF_BRK_OP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IR_W-1:0]  data_in,
  input  logic             irq,
  input  logic             nmi,
  input  logic             i_flag,
  input  logic             cyc_rst,
  input  logic             cyc_inc,
  input  logic             cyc_skip,
  output logic [IR_W-1:0]  ir,
  output logic [CYC_W-1:0] cycle,
  output logic [1:0]       int_src,
  output logic             sync,
  output logic             nmi_pend
);

  localparam logic [CYC_W-1:0] FETCH = CYC_W'(FETCH_CYC);

  logic [CYC_W-1:0] cycle_q, cycle_next;
  logic [IR_W-1:0]  ir_q, ir_next;
  int_src_t         src_q, src_next;
  logic             rst_pend_q, rst_pend_next;
  logic             nmi_pend_q, nmi_pend_next;
  logic             nmi_rise;
  logic             fetch;

  // NMI held high through reset must not look like a fresh edge.
  edge_det #(.RST_VAL(1'b1)) u_nmi_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (nmi),
    .rise (nmi_rise)
  );

  always_comb begin
    cycle_next = cycle_q;
    if (cyc_rst)       cycle_next = '0;
    else if (cyc_inc)  cycle_next = cycle_q + CYC_W'(1);
    else if (cyc_skip) cycle_next = cycle_q + CYC_W'(2);
  end

  // Only the transition into the fetch cycle reloads; holding there does not.
  assign fetch = (cycle_next == FETCH) && (cycle_q != FETCH);

  always_comb begin
    ir_next       = ir_q;
    src_next      = src_q;
    rst_pend_next = rst_pend_q;
    nmi_pend_next = nmi_pend_q | nmi_rise;
    if (fetch) begin
      if (rst_pend_q) begin
        ir_next       = BRK_OP;
        src_next      = INT_RST;
        rst_pend_next = 1'b0;
      end else if (nmi_pend_q || nmi_rise) begin
        // An edge arriving on the servicing clock is absorbed by this service.
        ir_next       = BRK_OP;
        src_next      = INT_NMI;
        nmi_pend_next = 1'b0;
      end else if (irq && !i_flag) begin
        ir_next  = BRK_OP;
        src_next = INT_IRQ;
      end else begin
        ir_next  = data_in;
        src_next = INT_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q    <= '0;
      ir_q       <= BRK_OP;
      src_q      <= INT_RST;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_next;
      ir_q       <= ir_next;
      src_q      <= src_next;
      rst_pend_q <= rst_pend_next;
      nmi_pend_q <= nmi_pend_next;
    end
  end

  assign ir       = ir_q;
  assign cycle    = cycle_q;
  assign int_src  = src_q;
  assign sync     = (cycle_q == FETCH);
  assign nmi_pend = nmi_pend_q;

endmodule

// File: tb/tb_instr_seq.sv
module tb_instr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       irq, nmi, i_flag;
  logic       cyc_rst, cyc_inc, cyc_skip;
  logic [7:0] ir;
  logic [2:0] cycle;
  logic [1:0] int_src;
  logic       sync;
  logic       nmi_pend;

  int checks = 0;
  int errors = 0;

  instr_seq dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .irq      (irq),
    .nmi      (nmi),
    .i_flag   (i_flag),
    .cyc_rst  (cyc_rst),
    .cyc_inc  (cyc_inc),
    .cyc_skip (cyc_skip),
    .ir       (ir),
    .cycle    (cycle),
    .int_src  (int_src),
    .sync     (sync),
    .nmi_pend (nmi_pend)
  );

  always #5 clk = ~clk;

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic i, input logic s);
    cyc_rst  = r;
    cyc_inc  = i;
    cyc_skip = s;
    @(posedge clk);
    #1;
    cyc_rst  = 1'b0;
    cyc_inc  = 1'b0;
    cyc_skip = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    checks++; if (cycle !== 3'd0) begin errors++; $display("FAIL reset_cycle got %h exp %h", cycle, 3'd0); end
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL reset_ir got %h exp %h", ir, 8'h00); end
    checks++; if (int_src !== 2'b11) begin errors++; $display("FAIL reset_src got %b exp %b", int_src, 2'b11); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset_sync got %b exp %b", sync, 1'b0); end
    checks++; if (nmi_pend !== 1'b0) begin errors++; $display("FAIL reset_nmi_pend got %b exp %b", nmi_pend, 1'b0); end
  endtask

  task automatic test_fetch_latency;
    data_in = 8'hA9;
    step(0, 1, 0);
    checks++; if (cycle !== 3'd1) begin errors++; $display("FAIL first_fetch_cycle got %h exp %h", cycle, 3'd1); end
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL first_fetch_ir got %h exp %h", ir, 8'h00); end
    checks++; if (int_src !== 2'b11) begin errors++; $display("FAIL first_fetch_src got %b exp %b", int_src, 2'b11); end
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL first_fetch_sync got %b exp %b", sync, 1'b1); end
    step(1, 0, 0);
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL cycrst_sync got %b exp %b", sync, 1'b0); end
    step(0, 1, 0);
    checks++; if (ir !== 8'hA9) begin errors++; $display("FAIL opcode_ir got %h exp %h", ir, 8'hA9); end
    checks++; if (int_src !== 2'b00) begin errors++; $display("FAIL opcode_src got %b exp %b", int_src, 2'b00); end
    data_in = 8'h55;
    step(0, 0, 0);
    checks++; if (ir !== 8'hA9) begin errors++; $display("FAIL hold_no_reload got %h exp %h", ir, 8'hA9); end
    checks++; if (cycle !== 3'd1) begin errors++; $display("FAIL hold_cycle got %h exp %h", cycle, 3'd1); end
  endtask

  task automatic test_skip_wrap;
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    checks++; if (cycle !== 3'd5) begin errors++; $display("FAIL skip_3_to_5 got %h exp %h", cycle, 3'd5); end
    step(0, 1, 0);
    step(0, 1, 0);
    checks++; if (cycle !== 3'd7) begin errors++; $display("FAIL at_7 got %h exp %h", cycle, 3'd7); end
    step(0, 1, 0);
    checks++; if (cycle !== 3'd0) begin errors++; $display("FAIL inc_wrap got %h exp %h", cycle, 3'd0); end
    checks++; if (ir !== 8'hA9) begin errors++; $display("FAIL inc_wrap_ir got %h exp %h", ir, 8'hA9); end
    data_in = 8'h33;
    step(0, 0, 1);
    checks++; if (ir !== 8'hA9) begin errors++; $display("FAIL skip_over_fetch_ir got %h exp %h", ir, 8'hA9); end
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    data_in = 8'hEA;
    step(0, 0, 1);
    checks++; if (cycle !== 3'd1) begin errors++; $display("FAIL skip_wrap got %h exp %h", cycle, 3'd1); end
    checks++; if (ir !== 8'hEA) begin errors++; $display("FAIL skip_wrap_fetch_ir got %h exp %h", ir, 8'hEA); end
    checks++; if (int_src !== 2'b00) begin errors++; $display("FAIL skip_wrap_src got %b exp %b", int_src, 2'b00); end
  endtask

  task automatic test_nmi;
    irq = 1'b1;
    i_flag = 1'b0;
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    nmi = 1'b1;
    step(0, 0, 0);
    checks++; if (nmi_pend !== 1'b1) begin errors++; $display("FAIL nmi_capture got %b exp %b", nmi_pend, 1'b1); end
    nmi = 1'b0;
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL nmi_ir got %h exp %h", ir, 8'h00); end
    checks++; if (int_src !== 2'b10) begin errors++; $display("FAIL nmi_src got %b exp %b", int_src, 2'b10); end
    checks++; if (nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_cleared got %b exp %b", nmi_pend, 1'b0); end
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (int_src !== 2'b01) begin errors++; $display("FAIL irq_after_nmi got %b exp %b", int_src, 2'b01); end
    irq = 1'b0;
  endtask

  task automatic test_irq_mask;
    irq = 1'b1;
    i_flag = 1'b1;
    data_in = 8'hEA;
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (ir !== 8'hEA) begin errors++; $display("FAIL irq_masked_ir got %h exp %h", ir, 8'hEA); end
    checks++; if (int_src !== 2'b00) begin errors++; $display("FAIL irq_masked_src got %b exp %b", int_src, 2'b00); end
    i_flag = 1'b0;
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL irq_taken_ir got %h exp %h", ir, 8'h00); end
    checks++; if (int_src !== 2'b01) begin errors++; $display("FAIL irq_taken_src got %b exp %b", int_src, 2'b01); end
    irq = 1'b0;
    data_in = 8'h4C;
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (ir !== 8'h4C) begin errors++; $display("FAIL irq_dropped_ir got %h exp %h", ir, 8'h4C); end
  endtask

  task automatic test_nmi_same_clock;
    data_in = 8'h18;
    step(1, 0, 0);
    nmi = 1'b1;
    step(0, 1, 0);
    checks++; if (int_src !== 2'b10) begin errors++; $display("FAIL nmi_same_clk_src got %b exp %b", int_src, 2'b10); end
    checks++; if (nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_same_clk_pend got %b exp %b", nmi_pend, 1'b0); end
    nmi = 1'b0;
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (ir !== 8'h18) begin errors++; $display("FAIL nmi_once_ir got %h exp %h", ir, 8'h18); end
    checks++; if (int_src !== 2'b00) begin errors++; $display("FAIL nmi_once_src got %b exp %b", int_src, 2'b00); end
  endtask

  task automatic test_nmi_through_reset;
    nmi = 1'b1;
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);
    checks++; if (nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_held_reset got %b exp %b", nmi_pend, 1'b0); end
    data_in = 8'hD8;
    step(0, 1, 0);
    checks++; if (int_src !== 2'b11) begin errors++; $display("FAIL post_rst_src got %b exp %b", int_src, 2'b11); end
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (ir !== 8'hD8) begin errors++; $display("FAIL nmi_held_no_fire got %h exp %h", ir, 8'hD8); end
    nmi = 1'b0;
    step(0, 1, 0);
    step(0, 1, 0);
    checks++; if (cycle !== 3'd3) begin errors++; $display("FAIL reach_3 got %h exp %h", cycle, 3'd3); end
    step(1, 1, 0);
    checks++; if (cycle !== 3'd0) begin errors++; $display("FAIL rst_inc_prio got %h exp %h", cycle, 3'd0); end
    checks++; if (ir !== 8'hD8) begin errors++; $display("FAIL rst_inc_no_reload got %h exp %h", ir, 8'hD8); end
  endtask

  task automatic test_rst_mid;
    data_in = 8'h20;
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    checks++; if (cycle !== 3'd4) begin errors++; $display("FAIL mid_cycle4 got %h exp %h", cycle, 3'd4); end
    nmi = 1'b1;
    step(0, 0, 0);
    nmi = 1'b0;
    checks++; if (nmi_pend !== 1'b1) begin errors++; $display("FAIL mid_nmi_pend got %b exp %b", nmi_pend, 1'b1); end
    rst = 1'b1;
    step(0, 1, 0);
    rst = 1'b0;
    checks++; if (cycle !== 3'd0) begin errors++; $display("FAIL mid_rst_cycle got %h exp %h", cycle, 3'd0); end
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL mid_rst_ir got %h exp %h", ir, 8'h00); end
    checks++; if (int_src !== 2'b11) begin errors++; $display("FAIL mid_rst_src got %b exp %b", int_src, 2'b11); end
    checks++; if (nmi_pend !== 1'b0) begin errors++; $display("FAIL mid_rst_nmi got %b exp %b", nmi_pend, 1'b0); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL mid_rst_sync got %b exp %b", sync, 1'b0); end
    step(0, 1, 0);
    checks++; if (int_src !== 2'b11) begin errors++; $display("FAIL mid_rst_service got %b exp %b", int_src, 2'b11); end
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (int_src !== 2'b00) begin errors++; $display("FAIL nmi_discarded got %b exp %b", int_src, 2'b00); end
    checks++; if (ir !== 8'h20) begin errors++; $display("FAIL nmi_discarded_ir got %h exp %h", ir, 8'h20); end
  endtask

  initial begin
    rst = 1'b1;
    data_in = 8'h00;
    irq = 1'b0;
    nmi = 1'b0;
    i_flag = 1'b0;
    cyc_rst = 1'b0;
    cyc_inc = 1'b0;
    cyc_skip = 1'b0;
    test_reset;
    test_fetch_latency;
    test_skip_wrap;
    test_nmi;
    test_irq_mask;
    test_nmi_same_clock;
    test_nmi_through_reset;
    test_rst_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
